res_writeback: RTL
==================

Name: res_writeback

Overview:
- Stage directly upstream of the result buffer.
- Accepts signed accumulator values from the MAC/PE array and requantizes each one: scale multiply, rounding right shift, then saturation to BIT_DEPTH.
- Drives the result buffer write port (wr_en, wr_addr, data) with a sequential address stream starting at a programmed base.
- Runs one job per start pulse and reports completion with a done pulse.

Parameters:
- BIT_DEPTH, 8: width of the requantized output word. Matches the result buffer data width.
- ADDR_WIDTH, 10: width of the result buffer write address.
- ACC_WIDTH, 24: width of the signed accumulator input.
- SCALE_WIDTH, 16: width of the unsigned requantization multiplier.
- SHIFT_WIDTH, 5: width of the right-shift amount (range 0..31).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first write address of the job.
- length  in  ADDR_WIDTH+1  number of values in the job (0..2^ADDR_WIDTH).
- scale  in  SCALE_WIDTH  unsigned multiplier.
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount.
- acc_in  in  ACC_WIDTH  signed accumulator value.
- acc_valid  in  1  acc_in is valid.
- acc_ready  out  1  block accepts acc_in this cycle.
- wr_en  out  1  write strobe to the result buffer.
- wr_addr  out  ADDR_WIDTH  result buffer write address.
- data_out  out  BIT_DEPTH  requantized value to write.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; pipeline valid bits and index counter clear.
  - All outputs are 0: acc_ready, wr_en, wr_addr, data_out, busy, done.
- State machine, states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start. base_addr, length, scale and shift are latched; the index counter is cleared.
  - start is ignored outside IDLE.
  - RUN: acc_ready = 1 while index < length. A beat is accepted when acc_valid && acc_ready, and index then increments.
  - RUN -> DRAIN once index == length. With length 0 this happens on the first RUN cycle.
  - DRAIN -> DONE when no pipeline stage holds a valid beat.
  - DONE lasts exactly one cycle with done = 1, then returns to IDLE.
- Pipeline: three registered stages; wr_en rises exactly 3 cycles after the accept edge.
  - S1 (multiply): p = acc_in * {0, scale}, signed, width ACC_WIDTH+SCALE_WIDTH+1. Beat address = base_addr + index, modulo 2^ADDR_WIDTH.
  - S2 (round and shift): if shift > 0, r = (p + 2^(shift-1)) >>> shift; otherwise r = p. Rounding is half-up toward +inf. Full width is kept, with no overflow.
  - S3 (saturate): clamp r to [-2^(BIT_DEPTH-1), 2^(BIT_DEPTH-1)-1]. data_out, wr_addr and wr_en are registered here.
- Output timing:
  - wr_en is high for exactly one cycle per accepted beat.
  - data_out and wr_addr hold their last value when wr_en = 0.
- Ordering and flow control:
  - Writes are issued in accept order with no reordering.
  - The pipeline never stalls, because the result buffer always accepts writes. Bubbles on acc_valid pass through as wr_en = 0 cycles.
- Boundaries:
  - Address wrap: after address 2^ADDR_WIDTH-1 the next address is 0.
  - length = 2^ADDR_WIDTH writes every address exactly once.
  - Reset mid-job discards all in-flight beats: no wr_en or done is issued after reset.

Optional Feature:
- Macro RES_WRITEBACK_RELU_EN.
- Defined: S3 clamps negative r to 0 before saturation, so output range is [0, 2^(BIT_DEPTH-1)-1].
- Undefined: plain signed saturation as described in Behaviour.
- Latency is identical in both builds.

Test Plan:
- Basic job: base=0, length=4, scale=1, shift=0, acc = 10, -5, 127, 200 back-to-back -> writes (addr, data) = (0,0x0A), (1,0xFB), (2,0x7F), (3,0x7F). Each wr_en is 3 cycles after its accept. done pulses once, 1 cycle after the last wr_en. With RES_WRITEBACK_RELU_EN the second write is 0x00.
- Rounding: scale=3, shift=2, acc = 5, -5, -6, -300 -> data = 4, -4, -4, -128 (saturated).
- Address wrap: base=1022, length=4 -> wr_addr sequence 1022, 1023, 0, 1, then done.
- Flow control: length=3 with acc_valid pattern 1,0,0,1,1,1 -> exactly 3 writes, with gaps mirroring the input bubbles. acc_ready drops after the third accept; the sixth valid beat is not consumed.
- Zero length and re-arm: length=0 -> no wr_en, busy high for RUN/DRAIN/DONE, a single done pulse, then IDLE. A start pulse asserted while busy has no effect.
- Reset mid-job: length=8, assert rst_n low with 2 beats in flight -> all outputs 0 immediately. No wr_en or done after release. A new start then runs normally from base.

Source files
------------

// File: rtl/res_writeback.sv
// -----------------------------------------------------------------------------
// res_writeback
//
// Requantizing write-back stage that sits directly in front of the result
// buffer. One job runs per start pulse. Each signed accumulator value accepted
// from the MAC/PE array passes through three registered stages:
//   S1  multiply by the unsigned scale
//   S2  rounding arithmetic right shift (half-up toward +inf)
//   S3  saturation to BIT_DEPTH, then drive the buffer write port
// Writes go to base_addr, base_addr+1, ... modulo 2^ADDR_WIDTH, in accept
// order. The result buffer always accepts writes, so the pipeline never
// stalls. Input bubbles appear on the write port as wr_en = 0 cycles.
//
// Optional build macro:
//   RES_WRITEBACK_RELU_EN  when defined, S3 clamps negative values to 0 before
//                          saturating (output range 0 .. 2^(BIT_DEPTH-1)-1).
//                          Latency is the same in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      job start pulse, sampled only while idle
//   base_addr  first write address of the job
//   length     number of values in the job (0 .. 2^ADDR_WIDTH)
//   scale      unsigned requantization multiplier
//   shift      arithmetic right-shift amount
//   acc_in     signed accumulator value
//   acc_valid  acc_in is valid
//   acc_ready  the block accepts acc_in this cycle
//   wr_en      result buffer write strobe (one cycle per accepted value)
//   wr_addr    result buffer write address (holds when wr_en = 0)
//   data_out   requantized write data (holds when wr_en = 0)
//   busy       high whenever a job is in progress
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module res_writeback #(
  parameter int BIT_DEPTH   = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int ACC_WIDTH   = 24,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH:0]    length,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [BIT_DEPTH-1:0]   data_out,
  output logic                   busy,
  output logic                   done
);

  // Product width: signed accumulator times a zero-extended (hence positive)
  // scale. The rounding stage carries one extra bit so that adding the
  // rounding constant can never overflow, whatever the shift amount.
  localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (BIT_DEPTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Job parameters, captured at start so the caller may change the inputs
  // while the job runs.
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [ADDR_WIDTH:0]    len_q;
  logic [SCALE_WIDTH-1:0] scale_q;
  logic [SHIFT_WIDTH-1:0] shift_q;

  // Number of values accepted so far in the current job.
  logic [ADDR_WIDTH:0]    index;

  logic accept;

  // Pipeline registers.
  logic                   s1_v;
  logic signed [PW-1:0]   s1_p;
  logic [ADDR_WIDTH-1:0]  s1_addr;
  logic                   s2_v;
  logic signed [RW-1:0]   s2_r;
  logic [ADDR_WIDTH-1:0]  s2_addr;

  // Combinational helpers.
  logic signed [PW-1:0]   acc_ext;
  logic signed [PW-1:0]   scale_ext;
  logic signed [PW-1:0]   prod;
  logic signed [RW-1:0]   p_ext;
  logic signed [RW-1:0]   half;
  logic signed [RW-1:0]   rnd_sum;
  logic signed [RW-1:0]   rounded;
  logic [BIT_DEPTH-1:0]   sat;

  // Ready is decoded from registered state only, so there is no
  // combinational path from any input to acc_ready.
  assign acc_ready = (state == RUN) && (index < len_q);
  assign accept    = acc_valid && acc_ready;

  // Job control. The state register, the captured job parameters, the index
  // counter and the busy/done flags all live here. DRAIN only waits for S1
  // and S2: whatever sits in S3 is already on the write port this cycle, so
  // done lands on the cycle right after the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      scale_q <= '0;
      shift_q <= '0;
      index   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base_addr;
            len_q   <= length;
            scale_q <= scale;
            shift_q <= shift;
            index   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            index <= index + 1'b1;
          end
          if (index == len_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_v && !s2_v) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // S1 operands: sign-extend the accumulator and zero-extend the scale, so
  // that a signed multiply of the two gives the exact product.
  always_comb begin
    acc_ext   = {{(PW - ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
    scale_ext = {{(PW - SCALE_WIDTH){1'b0}}, scale_q};
    prod      = acc_ext * scale_ext;
  end

  // S2 rounding: add half an LSB of the shifted result, then shift
  // arithmetically. The floor of (p + 2^(shift-1)) / 2^shift rounds halves
  // toward +inf for both signs. A shift of zero passes p through unchanged.
  always_comb begin
    p_ext = {s1_p[PW-1], s1_p};
    half  = '0;
    if (shift_q != '0) begin
      half = RW'(1) << (shift_q - 1'b1);
    end
    rnd_sum = p_ext + half;
    rounded = rnd_sum >>> shift_q;
  end

  // S3 saturation to the output word.
  always_comb begin
`ifdef RES_WRITEBACK_RELU_EN
    if (s2_r[RW-1]) begin
      sat = '0;
    end else if (s2_r > SAT_MAX) begin
      sat = SAT_MAX[BIT_DEPTH-1:0];
    end else begin
      sat = s2_r[BIT_DEPTH-1:0];
    end
`else
    if (s2_r > SAT_MAX) begin
      sat = SAT_MAX[BIT_DEPTH-1:0];
    end else if (s2_r < SAT_MIN) begin
      sat = SAT_MIN[BIT_DEPTH-1:0];
    end else begin
      sat = s2_r[BIT_DEPTH-1:0];
    end
`endif
  end

  // Three-stage datapath. The valid bits advance every cycle because the
  // result buffer never back-pressures. The data fields load only with a
  // valid beat, which is what makes wr_addr/data_out hold between writes.
  // Reset clears the valid bits, discarding every beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_p     <= '0;
      s1_addr  <= '0;
      s2_v     <= 1'b0;
      s2_r     <= '0;
      s2_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      data_out <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_p    <= prod;
        s1_addr <= base_q + index[ADDR_WIDTH-1:0];
      end

      s2_v <= s1_v;
      if (s1_v) begin
        s2_r    <= rounded;
        s2_addr <= s1_addr;
      end

      wr_en <= s2_v;
      if (s2_v) begin
        data_out <= sat;
        wr_addr  <= s2_addr;
      end
    end
  end

endmodule
